// File: rtl/gate_vector_checker.sv
// Stimulus/response checker for a 2-input gate: sweeps a/b through 00..11, compares y to the selected truth table.
// Latency: done rises 1 + 4*NUM_PASSES*(SETTLE_CYCLES+2) cycles after the accepting start edge.
// Backpressure: none; start is only sampled in IDLE, so requests while busy are dropped.
module gate_vector_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_PASSES    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] op_sel,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [1:0] first_fail,
  output logic       first_fail_valid
);

  typedef enum logic [1:0] {IDLE, HOLD, CHECK, FINISH} state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam logic [3:0] PASS_LAST = 4'(NUM_PASSES - 1);

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic       op_ok_q, op_ok_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] hold_q, hold_d;
  logic [3:0] pidx_q, pidx_d;
  logic [1:0] ab_q, ab_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] err_q, err_d;
  logic [1:0] ff_q, ff_d;
  logic       ffv_q, ffv_d;
  logic [3:0] exp_mask;

  // Expected y per vector, bit index = {a,b}
  function automatic logic [3:0] truth(input logic [2:0] op);
    case (op)
      3'd0:    truth = 4'b1000; // AND
      3'd1:    truth = 4'b1110; // OR
      3'd2:    truth = 4'b0111; // NAND
      3'd3:    truth = 4'b0001; // NOR
      3'd4:    truth = 4'b0110; // XOR
      3'd5:    truth = 4'b1001; // XNOR
      default: truth = 4'b0000;
    endcase
  endfunction

  assign exp_mask = truth(op_q);

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    op_ok_d = op_ok_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    pidx_d  = pidx_q;
    ab_d    = ab_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    ff_d    = ff_q;
    ffv_d   = ffv_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          err_d  = 4'd0;
          ff_d   = 2'd0;
          ffv_d  = 1'b0;
          pass_d = 1'b0;
          if (op_sel < 3'd6) begin
            op_d    = op_sel;
            op_ok_d = 1'b1;
            vec_d   = 2'd0;
            pidx_d  = 4'd0;
            hold_d  = SETTLE_LD;
            ab_d    = 2'd0;
            busy_d  = 1'b1;
            state_d = HOLD;
          end else begin
            // Invalid gate select: report a failed run without touching a/b
            op_ok_d = 1'b0;
            state_d = FINISH;
          end
        end
      end
      HOLD: begin
        if (hold_q == 4'd0) state_d = CHECK;
        else                hold_d  = hold_q - 4'd1;
      end
      CHECK: begin
        if (y != exp_mask[vec_q]) begin
          if (err_q != 4'd15) err_d = err_q + 4'd1;
          if (!ffv_q) begin
            ff_d  = vec_q;
            ffv_d = 1'b1;
          end
        end
        if (vec_q != 2'd3) begin
          vec_d   = vec_q + 2'd1;
          ab_d    = vec_q + 2'd1;
          hold_d  = SETTLE_LD;
          state_d = HOLD;
        end else if (pidx_q != PASS_LAST) begin
          vec_d   = 2'd0;
          ab_d    = 2'd0;
          pidx_d  = pidx_q + 4'd1;
          hold_d  = SETTLE_LD;
          state_d = HOLD;
        end else begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        ab_d    = 2'd0;
        pass_d  = op_ok_q && (err_q == 4'd0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 3'd0;
      op_ok_q <= 1'b0;
      vec_q   <= 2'd0;
      hold_q  <= 4'd0;
      pidx_q  <= 4'd0;
      ab_q    <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 4'd0;
      ff_q    <= 2'd0;
      ffv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      op_ok_q <= op_ok_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      pidx_q  <= pidx_d;
      ab_q    <= ab_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      ffv_q   <= ffv_d;
    end
  end

  assign a                = ab_q[1];
  assign b                = ab_q[0];
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail       = ff_q;
  assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
module tb_gate_vector_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  int         n_checks = 0;
  int         n_fail   = 0;

  // dut0: 1 pass, wrapped around a NOR gate model
  logic       start0;
  logic [2:0] op0;
  logic       y0, a0, b0, busy0, done0, pass0, ffv0;
  logic [3:0] err0;
  logic [1:0] ff0;

  // dut1: 8 passes, y tied high
  logic       start1;
  logic [2:0] op1;
  logic       y1, a1, b1, busy1, done1, pass1, ffv1;
  logic [3:0] err1;
  logic [1:0] ff1;

  always #5 clk = ~clk;

  assign y0 = ~(a0 | b0);
  assign y1 = 1'b1;

  gate_vector_checker #(.SETTLE_CYCLES(2), .NUM_PASSES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .op_sel(op0), .y(y0),
    .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_fail(ff0), .first_fail_valid(ffv0)
  );

  gate_vector_checker #(.SETTLE_CYCLES(2), .NUM_PASSES(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op_sel(op1), .y(y1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail(ff1), .first_fail_valid(ffv1)
  );

  task automatic start_run0(input logic [2:0] op);
    op0 = op; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
  endtask

  // Returns cycles from start edge to done, or -1 on timeout
  task automatic wait_done0(output int lat);
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (done0) begin lat = k; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; op0 = 3'd0; op1 = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if ({a0, b0} !== 2'b00) begin n_fail++; $display("FAIL reset_ab got=%b want=00", {a0, b0}); end
    n_checks++; if ({busy0, done0, pass0, ffv0} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got=%b want=0000", {busy0, done0, pass0, ffv0}); end
    n_checks++; if ({err0, ff0} !== 6'd0) begin n_fail++; $display("FAIL reset_counts got=%h want=0", {err0, ff0}); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset busy=%b done=%b want 0 0", busy0, done0); end
  endtask

  task automatic test_nor_pass;
    int lat;
    start_run0(3'd3);
    n_checks++; if (busy0 !== 1'b1 || {a0, b0} !== 2'b00) begin n_fail++; $display("FAIL nor_start busy=%b ab=%b want 1 00", busy0, {a0, b0}); end
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (k == 3)  begin n_checks++; if ({a0, b0} !== 2'b00) begin n_fail++; $display("FAIL nor_vec0 got=%b want=00", {a0, b0}); end end
      if (k == 5)  begin n_checks++; if ({a0, b0} !== 2'b01) begin n_fail++; $display("FAIL nor_vec1 got=%b want=01", {a0, b0}); end end
      if (k == 9)  begin n_checks++; if ({a0, b0} !== 2'b10) begin n_fail++; $display("FAIL nor_vec2 got=%b want=10", {a0, b0}); end end
      if (k == 13) begin n_checks++; if ({a0, b0} !== 2'b11) begin n_fail++; $display("FAIL nor_vec3 got=%b want=11", {a0, b0}); end end
      if (done0) begin lat = k; break; end
    end
    n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL nor_latency got=%0d want=17", lat); end
    n_checks++; if (pass0 !== 1'b1 || err0 !== 4'd0 || ffv0 !== 1'b0) begin n_fail++; $display("FAIL nor_result pass=%b err=%0d ffv=%b want 1 0 0", pass0, err0, ffv0); end
    n_checks++; if (busy0 !== 1'b0 || {a0, b0} !== 2'b00) begin n_fail++; $display("FAIL nor_finish busy=%b ab=%b want 0 00", busy0, {a0, b0}); end
    @(posedge clk); #1;
    n_checks++; if (done0 !== 1'b0 || pass0 !== 1'b1) begin n_fail++; $display("FAIL nor_done_pulse done=%b pass=%b want 0 1", done0, pass0); end
  endtask

  task automatic test_and_mismatch;
    int lat;
    start_run0(3'd0);
    wait_done0(lat);
    n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL and_latency got=%0d want=17", lat); end
    n_checks++; if (err0 !== 4'd2) begin n_fail++; $display("FAIL and_err got=%0d want=2", err0); end
    n_checks++; if (ffv0 !== 1'b1 || ff0 !== 2'b00) begin n_fail++; $display("FAIL and_first ffv=%b ff=%b want 1 00", ffv0, ff0); end
    n_checks++; if (pass0 !== 1'b0) begin n_fail++; $display("FAIL and_pass got=%b want=0", pass0); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (err0 !== 4'd2 || ffv0 !== 1'b1) begin n_fail++; $display("FAIL and_hold err=%0d ffv=%b want 2 1", err0, ffv0); end
  endtask

  task automatic test_saturate;
    int lat;
    op1 = 3'd0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (done1) begin lat = k; break; end
    end
    n_checks++; if (lat !== 129) begin n_fail++; $display("FAIL sat_latency got=%0d want=129", lat); end
    n_checks++; if (err1 !== 4'd15) begin n_fail++; $display("FAIL sat_err got=%0d want=15", err1); end
    n_checks++; if (ff1 !== 2'b00 || ffv1 !== 1'b1 || pass1 !== 1'b0) begin n_fail++; $display("FAIL sat_result ff=%b ffv=%b pass=%b want 00 1 0", ff1, ffv1, pass1); end
  endtask

  task automatic test_invalid_op;
    logic saw_busy, saw_ab;
    saw_busy = 1'b0; saw_ab = 1'b0;
    start_run0(3'd7);
    if (busy0) saw_busy = 1'b1;
    if (a0 | b0) saw_ab = 1'b1;
    n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL inv_done_early got=%b want=0", done0); end
    @(posedge clk); #1;
    if (busy0) saw_busy = 1'b1;
    if (a0 | b0) saw_ab = 1'b1;
    n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL inv_done got=%b want=1", done0); end
    n_checks++; if (pass0 !== 1'b0 || err0 !== 4'd0 || ffv0 !== 1'b0) begin n_fail++; $display("FAIL inv_result pass=%b err=%0d ffv=%b want 0 0 0", pass0, err0, ffv0); end
    @(posedge clk); #1;
    if (busy0) saw_busy = 1'b1;
    n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL inv_done_pulse got=%b want=0", done0); end
    n_checks++; if (saw_busy !== 1'b0 || saw_ab !== 1'b0) begin n_fail++; $display("FAIL inv_quiet busy_seen=%b ab_seen=%b want 0 0", saw_busy, saw_ab); end
  endtask

  task automatic test_busy_ignore;
    int lat;
    start_run0(3'd3);
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      #1;
      if (k == 5)  begin op0 = 3'd0; start0 = 1'b1; end
      if (k == 6)  start0 = 1'b0;
      if (k == 10) begin start0 = 1'b1; end
      if (k == 11) start0 = 1'b0;
      if (k == 9)  begin n_checks++; if ({a0, b0} !== 2'b10) begin n_fail++; $display("FAIL busy_vec2 got=%b want=10", {a0, b0}); end end
      if (k == 13) begin n_checks++; if ({a0, b0} !== 2'b11) begin n_fail++; $display("FAIL busy_vec3 got=%b want=11", {a0, b0}); end end
      if (done0) begin lat = k; break; end
    end
    n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL busy_latency got=%0d want=17", lat); end
    n_checks++; if (pass0 !== 1'b1 || err0 !== 4'd0 || ffv0 !== 1'b0) begin n_fail++; $display("FAIL busy_result pass=%b err=%0d ffv=%b want 1 0 0", pass0, err0, ffv0); end
    op0 = 3'd3;
  endtask

  task automatic test_reset_midrun;
    int lat;
    start_run0(3'd3);
    repeat (9) @(posedge clk);
    #1;
    n_checks++; if ({a0, b0} !== 2'b10 || busy0 !== 1'b1) begin n_fail++; $display("FAIL mid_pre ab=%b busy=%b want 10 1", {a0, b0}, busy0); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({a0, b0, busy0, done0, pass0, ffv0} !== 6'd0 || {err0, ff0} !== 6'd0) begin n_fail++; $display("FAIL mid_reset ab=%b busy=%b done=%b pass=%b err=%0d ff=%b ffv=%b want all 0", {a0, b0}, busy0, done0, pass0, err0, ff0, ffv0); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (busy0 !== 1'b0 || {a0, b0} !== 2'b00 || done0 !== 1'b0) begin n_fail++; $display("FAIL mid_idle busy=%b ab=%b done=%b want 0 00 0", busy0, {a0, b0}, done0); end
    start_run0(3'd3);
    wait_done0(lat);
    n_checks++; if (lat !== 17 || pass0 !== 1'b1) begin n_fail++; $display("FAIL mid_rerun lat=%0d pass=%b want 17 1", lat, pass0); end
  endtask

  initial begin
    test_reset;
    test_nor_pass;
    test_and_mismatch;
    test_saturate;
    test_invalid_op;
    test_busy_ignore;
    test_reset_midrun;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
